// File: rtl/spike_fire_unit_pkg.sv
// Shared types and constants for the spike fire unit and its saturating comparator.
package spike_fire_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StScan,
    StDone
  } state_e;

  localparam int unsigned MEM_W = 16;
  localparam logic signed [MEM_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [MEM_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/spike_sat_cmp.sv
// Saturates a post-accumulation voltage using the 17th sum bit, then applies the
// fire-and-subtract rule against the threshold.
module spike_sat_cmp
  import spike_fire_unit_pkg::*;
(
  input  logic signed [MEM_W-1:0] i_mem_vol,
  input  logic                    i_of_flag,
  input  logic signed [MEM_W-1:0] i_threshold,
  output logic signed [MEM_W-1:0] o_vol_next,
  output logic                    o_spike
);

  logic                    w_ovf;
  logic signed [MEM_W-1:0] w_sat;

  always_comb begin
    // Carry disagreeing with the sign bit means the true 17-bit sum is out of range.
    w_ovf = (i_of_flag != i_mem_vol[MEM_W-1]);
    w_sat = i_mem_vol;
    if (w_ovf) begin
      w_sat = i_of_flag ? SAT_MIN : SAT_MAX;
    end
    o_spike    = (w_sat >= i_threshold);
    o_vol_next = o_spike ? (w_sat - i_threshold) : w_sat;
  end

endmodule

// File: rtl/spike_fire_unit.sv
// Spike generation, writeback register, per-neuron spike counting over a window,
// and a sequential argmax scan that reports the winning neuron.
module spike_fire_unit
  import spike_fire_unit_pkg::*;
#(
  parameter int unsigned             NUM_NEURONS   = 20,
  parameter int unsigned             IDX_W         = 5,
  parameter logic signed [MEM_W-1:0] THRESHOLD     = 16'sd256,
  parameter int unsigned             NUM_TIMESTEPS = 16,
  parameter int unsigned             CNT_W         = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [IDX_W-1:0]        i_in_idx,
  input  logic signed [MEM_W-1:0] i_in_mem_vol,
  input  logic                    i_in_of_flag,
  input  logic                    i_in_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [IDX_W-1:0]        o_out_idx,
  output logic signed [MEM_W-1:0] o_out_vol,
  output logic                    o_out_spike,
  output logic                    o_result_valid,
  output logic [IDX_W-1:0]        o_result_idx,
  output logic [CNT_W-1:0]        o_result_cnt,
  output logic                    o_busy
);

  localparam int unsigned TS_W = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e                  r_state;
  logic [TS_W-1:0]         r_ts;
  logic [CNT_W-1:0]        r_cnt [NUM_NEURONS];
  logic [IDX_W-1:0]        r_scan_idx;
  logic [IDX_W-1:0]        r_best_idx;
  logic [CNT_W-1:0]        r_best_cnt;
  logic                    r_out_valid;
  logic [IDX_W-1:0]        r_out_idx;
  logic signed [MEM_W-1:0] r_out_vol;
  logic                    r_out_spike;
  logic                    r_result_valid;
  logic [IDX_W-1:0]        r_result_idx;
  logic [CNT_W-1:0]        r_result_cnt;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [MEM_W-1:0] w_vol_next;
  logic                    w_spike;
  logic [CNT_W-1:0]        w_scan_cnt;
  logic                    w_scan_better;

  spike_sat_cmp u_sat_cmp (
    .i_mem_vol   (i_in_mem_vol),
    .i_of_flag   (i_in_of_flag),
    .i_threshold (THRESHOLD),
    .o_vol_next  (w_vol_next),
    .o_spike     (w_spike)
  );

  assign w_in_ready = (r_state == StRun) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  // Counter read mux for the scan; keeps indexing within the array bounds.
  always_comb begin
    w_scan_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (r_scan_idx == IDX_W'(i)) begin
        w_scan_cnt = r_cnt[i];
      end
    end
    w_scan_better = (w_scan_cnt > r_best_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_ts           <= '0;
      r_scan_idx     <= '0;
      r_best_idx     <= '0;
      r_best_cnt     <= '0;
      r_out_valid    <= 1'b0;
      r_out_idx      <= '0;
      r_out_vol      <= '0;
      r_out_spike    <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_idx   <= '0;
      r_result_cnt   <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_result_valid <= 1'b0;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= i_in_idx;
        r_out_vol   <= w_vol_next;
        r_out_spike <= w_spike;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StRun;
            r_ts    <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
              r_cnt[i] <= '0;
            end
          end
        end

        StRun: begin
          if (w_accept) begin
            // Out-of-range indices never match, so they pass through uncounted.
            for (int i = 0; i < NUM_NEURONS; i++) begin
              if (w_spike && (i_in_idx == IDX_W'(i)) && (r_cnt[i] != CNT_MAX)) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
              end
            end
            if (i_in_last) begin
              if (r_ts == TS_W'(NUM_TIMESTEPS - 1)) begin
                r_ts       <= '0;
                r_state    <= StScan;
                r_scan_idx <= '0;
                r_best_idx <= '0;
                r_best_cnt <= '0;
              end else begin
                r_ts <= r_ts + TS_W'(1);
              end
            end
          end
        end

        StScan: begin
          // Strict compare keeps the lowest index on ties.
          if (w_scan_better) begin
            r_best_idx <= r_scan_idx;
            r_best_cnt <= w_scan_cnt;
          end
          if (r_scan_idx == IDX_W'(NUM_NEURONS - 1)) begin
            r_state        <= StDone;
            r_result_valid <= 1'b1;
            r_result_idx   <= w_scan_better ? r_scan_idx : r_best_idx;
            r_result_cnt   <= w_scan_better ? w_scan_cnt : r_best_cnt;
          end else begin
            r_scan_idx <= r_scan_idx + IDX_W'(1);
          end
        end

        StDone: begin
          r_state <= StIdle;
          for (int i = 0; i < NUM_NEURONS; i++) begin
            r_cnt[i] <= '0;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_idx      = r_out_idx;
  assign o_out_vol      = r_out_vol;
  assign o_out_spike    = r_out_spike;
  assign o_result_valid = r_result_valid;
  assign o_result_idx   = r_result_idx;
  assign o_result_cnt   = r_result_cnt;
  assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_spike_fire_unit.sv
// Scoreboard bench for spike_fire_unit: stimulus pushes expectations from an arithmetic
// reference model, a negedge monitor pops and compares outputs and window results.
module tb_spike_fire_unit;

  localparam int NN   = 20;
  localparam int IW   = 5;
  localparam int NT   = 2;
  localparam int CW   = 8;
  localparam int THR  = 256;
  localparam int CMAX = 255;

  typedef struct {
    int idx;
    int vol;
    bit spike;
  } exp_t;

  typedef struct {
    int  idx;
    int  cnt;
    time t_acc;
  } res_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [IW-1:0]       in_idx;
  logic signed [15:0]  in_mem_vol;
  logic                in_of_flag;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_idx;
  logic signed [15:0]  out_vol;
  logic                out_spike;
  logic                result_valid;
  logic [IW-1:0]       result_idx;
  logic [CW-1:0]       result_cnt;
  logic                busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  res_t res_q[$];
  int   m_cnt[NN];
  int   m_ts = 0;
  bit   m_active = 0;
  bit   rnd_ready = 0;

  always #5 clk = ~clk;

  spike_fire_unit #(
    .NUM_NEURONS   (NN),
    .IDX_W         (IW),
    .THRESHOLD     (16'sd256),
    .NUM_TIMESTEPS (NT),
    .CNT_W         (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_idx       (in_idx),
    .i_in_mem_vol   (in_mem_vol),
    .i_in_of_flag   (in_of_flag),
    .i_in_last      (in_last),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_idx      (out_idx),
    .o_out_vol      (out_vol),
    .o_out_spike    (out_spike),
    .o_result_valid (result_valid),
    .o_result_idx   (result_idx),
    .o_result_cnt   (result_cnt),
    .o_busy         (busy)
  );

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: treat {of, mem} as the true 17-bit signed sum and clamp it to 16 bits.
  task automatic model_accept(input int idx, input int mv, input bit of, input bit last);
    int   v;
    int   sat;
    exp_t e;
    res_t r;
    v   = of ? (mv - 65536) : mv;
    sat = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    e.idx   = idx;
    e.spike = (sat >= THR);
    e.vol   = e.spike ? (sat - THR) : sat;
    exp_q.push_back(e);
    if (e.spike && idx < NN && m_cnt[idx] < CMAX) m_cnt[idx]++;
    if (last) begin
      m_ts++;
      if (m_ts == NT) begin
        r.idx = 0;
        r.cnt = m_cnt[0];
        for (int i = 1; i < NN; i++) begin
          if (m_cnt[i] > r.cnt) begin
            r.idx = i;
            r.cnt = m_cnt[i];
          end
        end
        r.t_acc = $time;
        res_q.push_back(r);
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ts     = 0;
        m_active = 0;
      end
    end
  endtask

  task automatic send(input int idx, input int mv, input bit of, input bit last);
    int n = 0;
    in_valid   = 1'b1;
    in_idx     = IW'(idx);
    in_mem_vol = 16'(mv);
    in_of_flag = of;
    in_last    = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk(1'b0, "accept_timeout", n, 100);
    else model_accept(idx, mv & 32'hFFFF, of, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Raises start together with in_valid; nothing may be accepted in that cycle.
  task automatic start_window();
    start      = 1'b1;
    in_valid   = 1'b1;
    in_idx     = '0;
    in_mem_vol = 16'sd300;
    in_of_flag = 1'b0;
    @(negedge clk);
    chk(!busy, "idle_at_start", int'(busy), 0);
    chk(!in_ready, "idle_no_ready", int'(in_ready), 0);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ts     = 0;
    m_active = 1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (res_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() != 0) begin
      chk(1'b0, "result_timeout", n, 400);
      res_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic random_window();
    int k = 0;
    rnd_ready = 1;
    while (m_active && k < 500) begin
      send($urandom_range(0, 23), $urandom_range(0, 65535), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0));
      k++;
    end
    rnd_ready = 0;
    #0 out_ready = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  bit                 prev_stall = 0;
  bit                 busy_chk = 0;
  logic [IW-1:0]      p_idx;
  logic signed [15:0] p_vol;
  logic               p_spike;

  always @(negedge clk) begin
    exp_t e;
    res_t r;
    if (!rst_n) begin
      prev_stall = 0;
      busy_chk   = 0;
    end else begin
      if (prev_stall) begin
        chk(out_valid, "hold_valid", int'(out_valid), 1);
        chk(out_idx == p_idx && out_vol == p_vol && out_spike == p_spike, "hold_data",
            int'(out_vol), int'(p_vol));
      end
      if (out_valid && !out_ready) chk(!in_ready, "stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", int'(out_idx), -1);
        end else begin
          e = exp_q.pop_front();
          chk(int'(out_idx) == e.idx, "out_idx", int'(out_idx), e.idx);
          chk(int'(out_vol) == e.vol, "out_vol", int'(out_vol), e.vol);
          chk(out_spike == e.spike, "out_spike", int'(out_spike), int'(e.spike));
        end
      end
      prev_stall = out_valid && !out_ready;
      p_idx      = out_idx;
      p_vol      = out_vol;
      p_spike    = out_spike;
      if (busy_chk) begin
        chk(!busy, "busy_drop", int'(busy), 0);
        busy_chk = 0;
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          chk(1'b0, "unexpected_result", int'(result_idx), -1);
        end else begin
          r = res_q.pop_front();
          chk(int'(result_idx) == r.idx, "result_idx", int'(result_idx), r.idx);
          chk(int'(result_cnt) == r.cnt, "result_cnt", int'(result_cnt), r.cnt);
          chk(($time - r.t_acc) == time'((NN + 1) * 10), "result_latency",
              int'($time - r.t_acc), (NN + 1) * 10);
          chk(busy, "busy_in_done", int'(busy), 1);
        end
        busy_chk = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_idx     = '0;
    in_mem_vol = '0;
    in_of_flag = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(!out_valid, "rst_out_valid", int'(out_valid), 0);
    chk(!busy, "rst_busy", int'(busy), 0);
    chk(!in_ready, "rst_in_ready", int'(in_ready), 0);
    chk(!result_valid && result_idx == 0 && result_cnt == 0, "rst_result",
        int'(result_cnt), 0);
    chk(out_vol == 0 && out_idx == 0 && !out_spike, "rst_out_data", int'(out_vol), 0);
    @(posedge clk);
    #1;

    // Window 1: fire/saturation patterns, backpressure, then random traffic.
    start_window();
    send(0, 300, 1'b0, 1'b0);
    send(1, 255, 1'b0, 1'b0);
    send(2, 'h8005, 1'b0, 1'b0);
    send(3, 'h7FF0, 1'b1, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        send(4, 400, 1'b0, 1'b0);
        send(5, 100, 1'b0, 1'b0);
        send(6, -5, 1'b1, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    random_window();
    wait_done();

    // Window 2: neuron 1 fires twice, neuron 2 once.
    start_window();
    send(1, 300, 1'b0, 1'b0);
    send(2, 500, 1'b0, 1'b0);
    send(5, 100, 1'b0, 1'b1);
    send(1, 256, 1'b0, 1'b0);
    send(0, 10, 1'b0, 1'b1);
    wait_done();

    // Window 3: tie at the saturated count.
    start_window();
    for (int i = 0; i < 300; i++) begin
      send(3, 300, 1'b0, 1'b0);
      send(7, 300, 1'b0, (i == 149) || (i == 299));
    end
    wait_done();

    // Reset in RUN with a pending output item.
    start_window();
    out_ready = 1'b0;
    send(4, 1000, 1'b0, 1'b0);
    @(negedge clk);
    chk(out_valid, "pending_valid", int'(out_valid), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ts     = 0;
    m_active = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk(!out_valid, "rst_mid_out_valid", int'(out_valid), 0);
    chk(!busy, "rst_mid_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    start_window();
    random_window();
    wait_done();

    repeat (5) @(posedge clk);
    chk(exp_q.size() == 0, "drain_out", exp_q.size(), 0);
    chk(res_q.size() == 0, "drain_result", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
